// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants and helpers for the FFT input path.
//   SAMPLE_W : width of one real or imaginary sample.
//   lanes()  : number of samples per frame for a given log2 size.
//   bitrev() : bit-reversed lane index, used by the DIT lane map.
//   lane_lo(): low bit offset of lane k inside a packed frame bus.
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int SAMPLE_W = 16;

   function automatic int lanes(input int npoint);
      return 1 << npoint;
   endfunction

   function automatic int bitrev(input int idx, input int nbits);
      int r;
      r = 0;
      for (int b = 0; b < nbits; b++)
         r = r | (((idx >> b) & 1) << (nbits - 1 - b));
      return r;
   endfunction

   function automatic int lane_lo(input int k);
      return SAMPLE_W * k;
   endfunction

endpackage

// File: rtl/fft_lane_permute.sv
// ---------------------------------------------------------------------------
// fft_lane_permute
// Pure-wiring lane reorder of one packed frame bus.
//   din_i  : stored frame, lane k at bits [16k+15:16k]
//   dout_o : presented frame
// Build option FFT_DIN_BITREV_EN: when defined, output lane k carries input
// lane bitrev(k) so a decimation-in-time core sees bit-reversed order;
// otherwise the map is the identity.
// ---------------------------------------------------------------------------
module fft_lane_permute
   import fft_pkg::*;
#(
   parameter  int NPOINT  = 3,
   localparam int FRAME_W = SAMPLE_W << NPOINT
) (
   input  logic [FRAME_W-1:0] din_i,
   output logic [FRAME_W-1:0] dout_o
);

   for (genvar k = 0; k < lanes(NPOINT); k++) begin : g_lane
`ifdef FFT_DIN_BITREV_EN
      localparam int SRC = bitrev(k, NPOINT);
`else
      localparam int SRC = k;
`endif
      assign dout_o[lane_lo(k) +: SAMPLE_W] = din_i[lane_lo(SRC) +: SAMPLE_W];
   end

endmodule

// File: rtl/fft_din_pingpong.sv
// ---------------------------------------------------------------------------
// fft_din_pingpong
// Two-bank ping-pong frame buffer between the USB host side and the FFT core.
//   clk, rst                 : clock, asynchronous active-high reset
//   fft_din_valid/_busy      : upstream frame handshake (push when valid & !busy)
//   fft_din_real/_imag       : upstream frame, 2^NPOINT lanes of 16 bits
//   core_valid/core_ready    : downstream frame handshake (pop when both high)
//   core_real/core_imag      : presented frame, after the lane map
//   fill_level               : stored frames, 0..2
//   frame_cnt                : frames popped, wraps silently
// Build option FFT_DIN_BITREV_EN selects bit-reversed output lane order.
// All outputs decode registered state only, so there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module fft_din_pingpong
   import fft_pkg::*;
#(
   parameter  int NPOINT  = 3,
   parameter  int CNT_W   = 16,
   localparam int FRAME_W = SAMPLE_W << NPOINT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fft_din_valid,
   output logic               fft_din_busy,
   input  logic [FRAME_W-1:0] fft_din_real,
   input  logic [FRAME_W-1:0] fft_din_imag,
   output logic               core_valid,
   input  logic               core_ready,
   output logic [FRAME_W-1:0] core_real,
   output logic [FRAME_W-1:0] core_imag,
   output logic [1:0]         fill_level,
   output logic [CNT_W-1:0]   frame_cnt
);

   logic [FRAME_W-1:0] bank_re_q [2];
   logic [FRAME_W-1:0] bank_im_q [2];
   logic               wr_sel_q, wr_sel_d;
   logic               rd_sel_q, rd_sel_d;
   logic [1:0]         count_q, count_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic               push, pop;

   assign fft_din_busy = (count_q == 2'd2);
   assign core_valid   = (count_q != 2'd0);
   assign fill_level   = count_q;
   assign frame_cnt    = frame_cnt_q;

   // busy/valid come from count_q, so a push is never taken while full even
   // if the core pops in the same cycle; at count==1 push and pop target
   // different banks because wr_sel != rd_sel there.
   assign push = fft_din_valid && !fft_din_busy;
   assign pop  = core_valid && core_ready;

   always_comb begin
      wr_sel_d    = wr_sel_q ^ push;
      rd_sel_d    = rd_sel_q ^ pop;
      frame_cnt_d = pop ? frame_cnt_q + 1'b1 : frame_cnt_q;
      count_d     = count_q;
      if (push && !pop)
         count_d = count_q + 2'd1;
      else if (pop && !push)
         count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_sel_q     <= 1'b0;
         rd_sel_q     <= 1'b0;
         count_q      <= 2'd0;
         frame_cnt_q  <= '0;
         bank_re_q[0] <= '0;
         bank_re_q[1] <= '0;
         bank_im_q[0] <= '0;
         bank_im_q[1] <= '0;
      end else begin
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         count_q     <= count_d;
         frame_cnt_q <= frame_cnt_d;
         if (push) begin
            bank_re_q[wr_sel_q] <= fft_din_real;
            bank_im_q[wr_sel_q] <= fft_din_imag;
         end
      end
   end

   fft_lane_permute #(.NPOINT(NPOINT)) u_perm_re (
      .din_i  (bank_re_q[rd_sel_q]),
      .dout_o (core_real)
   );

   fft_lane_permute #(.NPOINT(NPOINT)) u_perm_im (
      .din_i  (bank_im_q[rd_sel_q]),
      .dout_o (core_imag)
   );

endmodule

// File: tb/tb_fft_din_pingpong.sv
module tb_fft_din_pingpong;

   localparam int NP    = 3;
   localparam int NL    = 1 << NP;
   localparam int FW    = 16 * NL;

   typedef logic [FW-1:0] frame_t;

   logic         clk, rst;
   logic         fft_din_valid, fft_din_busy;
   frame_t       fft_din_real, fft_din_imag;
   logic         core_valid, core_ready;
   frame_t       core_real, core_imag;
   logic [1:0]   fill_level;
   logic [15:0]  frame_cnt;

   fft_din_pingpong #(.NPOINT(NP), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .fft_din_valid (fft_din_valid),
      .fft_din_busy  (fft_din_busy),
      .fft_din_real  (fft_din_real),
      .fft_din_imag  (fft_din_imag),
      .core_valid    (core_valid),
      .core_ready    (core_ready),
      .core_real     (core_real),
      .core_imag     (core_imag),
      .fill_level    (fill_level),
      .frame_cnt     (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---- reference model: FIFO of frames plus a pop counter ----
   frame_t      q_re[$];
   frame_t      q_im[$];
   logic [15:0] mcnt;

   function automatic int rev(input int k);
      int r = 0;
      for (int b = 0; b < NP; b++)
         if ((k >> b) & 1) r = r + (1 << (NP - 1 - b));
      return r;
   endfunction

   // Expected presentation order of a stored frame.
   function automatic frame_t perm(input frame_t f);
      frame_t o;
      int src;
      o = '0;
      for (int k = 0; k < NL; k++) begin
`ifdef FFT_DIN_BITREV_EN
         src = rev(k);
`else
         src = k;
`endif
         o[16*k +: 16] = f[16*src +: 16];
      end
      return o;
   endfunction

   function automatic frame_t mk_re(input logic [7:0] tag);
      frame_t f;
      for (int k = 0; k < NL; k++) f[16*k +: 16] = {tag, 8'(k)};
      return f;
   endfunction

   function automatic frame_t mk_im(input logic [7:0] tag);
      frame_t f;
      for (int k = 0; k < NL; k++) f[16*k +: 16] = {tag + 8'd1, 8'(k)};
      return f;
   endfunction

   function automatic frame_t rnd_frame();
      frame_t f;
      for (int k = 0; k < NL; k++) f[16*k +: 16] = 16'($urandom);
      return f;
   endfunction

   // One cycle: drive at negedge, clock, update model, check at next negedge.
   task automatic step(input logic v, input logic r, input frame_t re, input frame_t im, input bit chk);
      bit do_push, do_pop;
      fft_din_valid = v;
      core_ready    = r;
      fft_din_real  = re;
      fft_din_imag  = im;
      do_push = v && (q_re.size() < 2);
      do_pop  = r && (q_re.size() > 0);
      @(posedge clk);
      if (do_pop) begin
         void'(q_re.pop_front());
         void'(q_im.pop_front());
         mcnt = mcnt + 16'd1;
      end
      if (do_push) begin
         q_re.push_back(re);
         q_im.push_back(im);
      end
      @(negedge clk);
      if (chk) begin
         cmp("busy",  FW'(fft_din_busy), FW'(q_re.size() == 2));
         cmp("valid", FW'(core_valid),   FW'(q_re.size() != 0));
         cmp("fill",  FW'(fill_level),   FW'(q_re.size()));
         cmp("cnt",   FW'(frame_cnt),    FW'(mcnt));
         if (q_re.size() != 0) begin
            cmp("real", core_real, perm(q_re[0]));
            cmp("imag", core_imag, perm(q_im[0]));
         end
      end
   endtask

   typedef struct {
      logic        v;
      logic        r;
      logic [7:0]  tin;
      logic        eb;
      logic        ev;
      logic [1:0]  ef;
      logic [15:0] ecnt;
      bit          cd;
      logic [7:0]  etag;
   } vec_t;

   vec_t tbl[9];

   initial begin
      // A=tag 1, B=tag 3, C=tag 5, D=tag 7
      tbl[0] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 2'd1, 16'd0, 1'b1, 8'h01}; // push A
      tbl[1] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 2'd2, 16'd0, 1'b1, 8'h01}; // push B -> full
      tbl[2] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 2'd2, 16'd0, 1'b1, 8'h01}; // C held
      tbl[3] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 2'd1, 16'd1, 1'b1, 8'h03}; // pop A, C blocked
      tbl[4] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 2'd2, 16'd1, 1'b1, 8'h03}; // C lands
      tbl[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 16'd2, 1'b1, 8'h05}; // pop B
      tbl[6] = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 2'd1, 16'd3, 1'b1, 8'h07}; // push D + pop C
      tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 16'd4, 1'b0, 8'h00}; // pop D
      tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 16'd4, 1'b0, 8'h00}; // ready while empty

      rst = 1'b1;
      fft_din_valid = 1'b0;
      core_ready = 1'b0;
      fft_din_real = '0;
      fft_din_imag = '0;
      mcnt = '0;
      #1;
      cmp("rst_busy",  FW'(fft_din_busy), '0);
      cmp("rst_valid", FW'(core_valid),   '0);
      cmp("rst_fill",  FW'(fill_level),   '0);
      cmp("rst_cnt",   FW'(frame_cnt),    '0);
      cmp("rst_real",  core_real,         '0);
      cmp("rst_imag",  core_imag,         '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // ---- directed table ----
      for (int i = 0; i < 9; i++) begin
         fft_din_valid = tbl[i].v;
         core_ready    = tbl[i].r;
         fft_din_real  = mk_re(tbl[i].tin);
         fft_din_imag  = mk_im(tbl[i].tin);
         @(posedge clk);
         @(negedge clk);
         cmp($sformatf("t%0d_busy", i),  FW'(fft_din_busy), FW'(tbl[i].eb));
         cmp($sformatf("t%0d_valid", i), FW'(core_valid),   FW'(tbl[i].ev));
         cmp($sformatf("t%0d_fill", i),  FW'(fill_level),   FW'(tbl[i].ef));
         cmp($sformatf("t%0d_cnt", i),   FW'(frame_cnt),    FW'(tbl[i].ecnt));
         if (tbl[i].cd) begin
            cmp($sformatf("t%0d_real", i), core_real, perm(mk_re(tbl[i].etag)));
            cmp($sformatf("t%0d_imag", i), core_imag, perm(mk_im(tbl[i].etag)));
         end
         if (i == 0) begin
`ifdef FFT_DIN_BITREV_EN
            cmp("lane3", FW'(core_real[48 +: 16]), FW'(16'h0106));
`else
            cmp("lane3", FW'(core_real[48 +: 16]), FW'(16'h0103));
`endif
         end
      end

      // ---- reset while full, with a push in the reset cycle ----
      core_ready = 1'b0;
      fft_din_valid = 1'b1;
      fft_din_real = mk_re(8'h11); fft_din_imag = mk_im(8'h11);
      @(posedge clk); @(negedge clk);
      fft_din_real = mk_re(8'h13); fft_din_imag = mk_im(8'h13);
      @(posedge clk); @(negedge clk);
      cmp("pre_rst_fill", FW'(fill_level), FW'(2));
      fft_din_real = mk_re(8'h15); fft_din_imag = mk_im(8'h15);
      rst = 1'b1;
      #1;
      cmp("mid_rst_busy",  FW'(fft_din_busy), '0);
      cmp("mid_rst_valid", FW'(core_valid),   '0);
      cmp("mid_rst_fill",  FW'(fill_level),   '0);
      cmp("mid_rst_real",  core_real,         '0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      fft_din_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      cmp("post_rst_fill", FW'(fill_level), '0);
      q_re.delete(); q_im.delete(); mcnt = '0;
      step(1'b1, 1'b0, mk_re(8'h21), mk_im(8'h21), 1'b1);
      step(1'b1, 1'b0, mk_re(8'h23), mk_im(8'h23), 1'b1);
      cmp("first_out", core_real, perm(mk_re(8'h21)));
      step(1'b0, 1'b1, '0, '0, 1'b1);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_frame(), rnd_frame(), 1'b1);

      // ---- counter wrap: stream one pop per cycle up to 0xFFFF ----
      while (q_re.size() > 0) step(1'b0, 1'b1, '0, '0, 1'b1);
      step(1'b1, 1'b0, rnd_frame(), rnd_frame(), 1'b1);
      while (mcnt != 16'hFFFF) step(1'b1, 1'b1, rnd_frame(), rnd_frame(), 1'b0);
      cmp("cnt_max", FW'(frame_cnt), FW'(16'hFFFF));
      step(1'b1, 1'b1, rnd_frame(), rnd_frame(), 1'b1);
      cmp("cnt_wrap", FW'(frame_cnt), FW'(16'h0000));
      step(1'b0, 1'b1, '0, '0, 1'b1);
      cmp("cnt_after", FW'(frame_cnt), FW'(16'h0001));
      step(1'b0, 1'b1, '0, '0, 1'b1);
      cmp("cnt_empty_pop", FW'(frame_cnt), FW'(16'h0001));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
